// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_adder
// Brief    : Pipelined carry-lookahead adder/subtractor with valid/ready on
//            both sides. WIDTH is cut into GROUP-bit lookahead groups and
//            STAGE_GRPS groups are resolved per stage, so there are
//            LAT = WIDTH/(GROUP*STAGE_GRPS) stages. An input register folds
//            subtraction into an inverted B with a forced carry-in.
//            Optional flags: define CLA_FLAGS_EN to add out_ovf/out_zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder #(
  parameter int WIDTH      = 32,
  parameter int GROUP      = 4,
  parameter int STAGE_GRPS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CLA_FLAGS_EN
  ,
  output logic             out_ovf,
  output logic             out_zero
`endif
);

  localparam int CHUNK = GROUP * STAGE_GRPS;
  localparam int LAT   = WIDTH / CHUNK;

  // Unresolved operand bits shrink by CHUNK per stage and resolved sum bits
  // grow by CHUNK; both are packed back to back in flat vectors.
  function automatic int op_off(input int j);
    return j * WIDTH - (CHUNK * j * (j - 1)) / 2;
  endfunction

  function automatic int sum_off(input int j);
    return (CHUNK * j * (j + 1)) / 2;
  endfunction

  localparam int OP_TOT  = op_off(LAT);
  localparam int SUM_TOT = sum_off(LAT - 1) + WIDTH;

  if (((WIDTH % CHUNK) != 0) || (WIDTH < CHUNK)) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of GROUP*STAGE_GRPS");
  end

  // Closed-form lookahead carries of one group: co[j] is the carry out of bit j.
  function automatic logic [GROUP-1:0] cla_group(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic             ci);
    logic [GROUP-1:0] co;
    logic             term;
    co = '0;
    for (int j = 0; j < GROUP; j++) begin
      term = ci;
      for (int m = 0; m <= j; m++) term = term & p[m];
      co[j] = term;
      for (int i = 0; i <= j; i++) begin
        term = g[i];
        for (int m = i + 1; m <= j; m++) term = term & p[m];
        co[j] = co[j] | term;
      end
    end
    return co;
  endfunction

  wire              adv;
  wire [LAT:0]      stg_vld;
  wire [LAT:0]      stg_cry;
  wire [OP_TOT-1:0] stg_a;
  wire [OP_TOT-1:0] stg_b;
  wire [SUM_TOT-1:0] stg_sum;

  // The whole pipeline moves as one; it only freezes when a result is refused.
  assign adv      = !stg_vld[LAT] || out_ready;
  assign in_ready = adv;

  logic             in_vld_q;
  logic             in_cry_q;
  logic [WIDTH-1:0] in_a_q;
  logic [WIDTH-1:0] in_b_q;

  // Capture operands; subtraction becomes A + ~B + 1 here so later stages only add.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_vld_q <= 1'b0;
      in_cry_q <= 1'b0;
      in_a_q   <= '0;
      in_b_q   <= '0;
    end else if (adv) begin
      in_vld_q <= in_valid;
      if (in_valid) begin
        in_a_q   <= in_a;
        in_b_q   <= in_sub ? ~in_b : in_b;
        in_cry_q <= in_sub | in_cin;
      end
    end
  end

  assign stg_vld[0]         = in_vld_q;
  assign stg_cry[0]         = in_cry_q;
  assign stg_a[WIDTH-1:0]   = in_a_q;
  assign stg_b[WIDTH-1:0]   = in_b_q;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    localparam int LO  = k * CHUNK;
    localparam int OPB = op_off(k);

    logic [CHUNK-1:0]    p_d;
    logic [CHUNK-1:0]    g_d;
    logic [CHUNK-1:0]    s_d;
    logic [CHUNK:0]      c_d;
    logic [LO+CHUNK-1:0] sum_d;
    logic                vld_q;
    logic                cry_q;
    logic [LO+CHUNK-1:0] sum_q;

    assign p_d = stg_a[OPB +: CHUNK] ^ stg_b[OPB +: CHUNK];
    assign g_d = stg_a[OPB +: CHUNK] & stg_b[OPB +: CHUNK];

    // Groups inside a stage chain their group carries; bits inside a group use lookahead.
    always_comb begin
      c_d    = '0;
      c_d[0] = stg_cry[k];
      for (int grp = 0; grp < STAGE_GRPS; grp++) begin
        c_d[grp*GROUP+1 +: GROUP] = cla_group(p_d[grp*GROUP +: GROUP],
                                              g_d[grp*GROUP +: GROUP],
                                              c_d[grp*GROUP]);
      end
    end

    assign s_d = p_d ^ c_d[CHUNK-1:0];

    if (k == 0) begin : g_first
      assign sum_d = s_d;
    end else begin : g_rest
      assign sum_d = {s_d, stg_sum[sum_off(k-1) +: LO]};
    end

    // Register resolved low sum bits and the outgoing carry; data holds across bubbles.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cry_q <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= stg_vld[k];
        if (stg_vld[k]) begin
          cry_q <= c_d[CHUNK];
          sum_q <= sum_d;
        end
      end
    end

    assign stg_vld[k+1]                   = vld_q;
    assign stg_cry[k+1]                   = cry_q;
    assign stg_sum[sum_off(k) +: LO+CHUNK] = sum_q;

    if (k < LAT - 1) begin : g_pass
      localparam int RW = WIDTH - LO - CHUNK;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;

      // Forward the still-unresolved upper operand bits to the next stage.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && stg_vld[k]) begin
          a_q <= stg_a[OPB+CHUNK +: RW];
          b_q <= stg_b[OPB+CHUNK +: RW];
        end
      end

      assign stg_a[op_off(k+1) +: RW] = a_q;
      assign stg_b[op_off(k+1) +: RW] = b_q;
    end

`ifdef CLA_FLAGS_EN
    if (k == LAT - 1) begin : g_flags
      logic ovf_q;
      logic zero_q;

      // Flags ride with the final sum: overflow from the two top carries, zero from the full sum.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv && stg_vld[k]) begin
          ovf_q  <= c_d[CHUNK-1] ^ c_d[CHUNK];
          zero_q <= ~|sum_d;
        end
      end

      assign out_ovf  = ovf_q;
      assign out_zero = zero_q;
    end
`endif
  end

  assign out_valid = stg_vld[LAT];
  assign out_cout  = stg_cry[LAT];
  assign out_sum   = stg_sum[sum_off(LAT-1) +: WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_cla_adder
// Brief    : Self-checking bench for pipelined_cla_adder (defaults, LAT=4).
//            Directed vector table, random streaming against an arithmetic
//            reference model, backpressure stall and mid-stream reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_cla_adder;

  localparam int WIDTH = 32;
  localparam int LAT   = 4;
  localparam int NV    = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef CLA_FLAGS_EN
  logic             out_ovf;
  logic             out_zero;
`endif

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(WIDTH), .GROUP(4), .STAGE_GRPS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef CLA_FLAGS_EN
    ,
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the effective operands.
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    logic             ce;
    res_t             r;
    bb     = sub ? ~b : b;
    ce     = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ce};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  res_t exp_q[$];
  int   run_len  = 0;
  int   max_run  = 0;
  int   seen_out = 0;

  // Scoreboard: transfers are judged at the negedge before the edge that performs them.
  always @(negedge clk) begin : mon
    res_t e;
    if (out_valid && out_ready) begin
      seen_out++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got sum 0x%0h, want no beat", out_sum);
      end else begin
        e = exp_q.pop_front();
        check("stream_sum_cout", 64'({out_sum, out_cout}), 64'({e.sum, e.cout}));
`ifdef CLA_FLAGS_EN
        check("stream_flags", 64'({out_ovf, out_zero}), 64'({e.ovf, e.zero}));
`endif
      end
    end
    if (!rst_n) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
    if (out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  // Offer one beat and return just after the edge that accepts it.
  task automatic push_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub);
    int w;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    w        = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: in_ready 0, want 1");
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } vec_t;

  vec_t vt[NV];
  int   lat;
  int   s0;

  initial begin
    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vt[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vt[2] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vt[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vt[4] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vt[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vt[6] = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    vt[7] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vt[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vt[9] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready",  64'(in_ready),  64'(1));
    check("reset_out_sum",   64'(out_sum),   64'(0));
    check("reset_out_cout",  64'(out_cout),  64'(0));

    // Directed vectors, one at a time, with exact latency.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = vt[i].a;
      in_b     = vt[i].b;
      in_cin   = vt[i].cin;
      in_sub   = vt[i].sub;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        @(posedge clk);
        #1;
        if (out_valid) lat = c;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_sum_cout", i), 64'({out_sum, out_cout}), 64'({vt[i].sum, vt[i].cout}));
`ifdef CLA_FLAGS_EN
      check($sformatf("vec%0d_flags", i), 64'({out_ovf, out_zero}), 64'({vt[i].ovf, vt[i].zero}));
`endif
    end

    // 16 random back-to-back beats must come out as 16 consecutive valid cycles.
    repeat (3) @(posedge clk);
    #1;
    max_run = 0;
    s0      = seen_out;
    for (int i = 0; i < 16; i++) push_beat(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("stream_run_len", 64'(max_run), 64'(16));
    check("stream_count",   64'(seen_out - s0), 64'(16));

    // Full pipeline, then refuse results for three cycles.
    s0 = seen_out;
    fork
      begin
        for (int i = 0; i < 12; i++) push_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check($sformatf("stall%0d_in_ready", c),  64'(in_ready),  64'(0));
          check($sformatf("stall%0d_out_valid", c), 64'(out_valid), 64'(1));
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL stall%0d_head: scoreboard empty, want a pending beat", c);
          end else begin
            check($sformatf("stall%0d_held", c), 64'({out_sum, out_cout}), 64'({exp_q[0].sum, exp_q[0].cout}));
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    check("stall_drain_empty", 64'(exp_q.size()), 64'(0));
    check("stall_count",       64'(seen_out - s0), 64'(12));

    // Reset with three beats in flight: they must vanish.
    for (int i = 0; i < 3; i++) push_beat($urandom | 32'h1, $urandom, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready",  64'(in_ready),  64'(1));
    check("midrst_out_sum",   64'(out_sum),   64'(0));
    check("midrst_out_cout",  64'(out_cout),  64'(0));
`ifdef CLA_FLAGS_EN
    check("midrst_flags", 64'({out_ovf, out_zero}), 64'(0));
`endif
    s0 = seen_out;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_emerge", 64'(seen_out - s0), 64'(0));

    // Pipeline still works after the reset.
    push_beat(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_count", 64'(seen_out - s0), 64'(1));
    check("final_drain_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
